sysid_reader: RTL and testbench



---
 rtl/sysid_reader_pkg.sv | 33 +++
 rtl/sysid_reader_txn.sv | 85 ++++++++
 rtl/sysid_reader.sv | 162 ++++++++++++++++
 tb/tb_sysid_reader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_reader_pkg.sv
// Shared types and constants for the system-ID reader.
// The default ID/timestamp values are also consumed by the sysid generator scripts.
package sysid_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ_ID  = 3'd1,
        ST_WAIT_ID = 3'd2,
        ST_REQ_TS  = 3'd3,
        ST_WAIT_TS = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_WAIT = 2'd2
    } txn_state_e;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h0000_1337;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h5672_A766;

    localparam int TMO_W = 16;

    // Last counter value a transaction may reach before it is abandoned.
    function automatic logic [TMO_W-1:0] tmo_last(input int cycles);
        return TMO_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/sysid_reader_txn.sv
// Single Avalon-MM read with a per-transaction timeout covering request and data wait.
// The counter restarts on every go and never runs past its last value.
module sysid_reader_txn
    import sysid_reader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        go_i,
    input  logic        addr_i,
    input  logic        avm_waitrequest_i,
    input  logic [31:0] avm_readdata_i,
    input  logic        avm_readdatavalid_i,
    output logic        avm_read_o,
    output logic        avm_address_o,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        timed_out_o
);

    localparam logic [TMO_W-1:0] CNT_LAST = tmo_last(TIMEOUT_CYCLES);

    txn_state_e       state_q, state_d;
    logic             addr_q, addr_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= TX_IDLE;
            addr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        valid_o     = 1'b0;
        timed_out_o = 1'b0;

        case (state_q)
            TX_REQ: begin
                cnt_d = cnt_q + TMO_W'(1);
                // Data cannot arrive in the acceptance cycle, so the last count aborts even if accepted.
                if (cnt_q == CNT_LAST) begin
                    timed_out_o = 1'b1;
                    state_d     = TX_IDLE;
                    cnt_d       = '0;
                end else if (!avm_waitrequest_i) begin
                    state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                cnt_d = cnt_q + TMO_W'(1);
                if (avm_readdatavalid_i) begin
                    valid_o = 1'b1;
                    state_d = TX_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    timed_out_o = 1'b1;
                    state_d     = TX_IDLE;
                    cnt_d       = '0;
                end
            end
            default: ;
        endcase

        if (go_i) begin
            state_d = TX_REQ;
            addr_d  = addr_i;
            cnt_d   = '0;
        end
    end

    assign avm_read_o    = (state_q == TX_REQ);
    assign avm_address_o = avm_read_o & addr_q;
    assign data_o        = avm_readdata_i;

endmodule

// File: rtl/sysid_reader.sv
// Reads the sysid ID and build-timestamp words and checks them against expected values.
// Results are held until the next accepted start.
//
//   state    | meaning
//   ---------+----------------------------------------------
//   IDLE     | after reset; waits for start (or auto-start)
//   REQ_ID   | read request for ID word (address 0)
//   WAIT_ID  | waiting for ID data
//   REQ_TS   | read request for timestamp word (address 1)
//   WAIT_TS  | waiting for timestamp data
//   DONE     | results valid; start begins a new check
module sysid_reader
    import sysid_reader_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_e      state_q, state_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic        pass_q, pass_d;

    logic        txn_go;
    logic        txn_addr;
    logic [31:0] txn_data;
    logic        txn_valid;
    logic        txn_timed_out;

    sysid_reader_txn #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_txn (
        .clock               (clock),
        .reset               (reset),
        .go_i                (txn_go),
        .addr_i              (txn_addr),
        .avm_waitrequest_i   (avm_waitrequest),
        .avm_readdata_i      (avm_readdata),
        .avm_readdatavalid_i (avm_readdatavalid),
        .avm_read_o          (avm_read),
        .avm_address_o       (avm_address),
        .data_o              (txn_data),
        .valid_o             (txn_valid),
        .timed_out_o         (txn_timed_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            id_value_q <= '0;
            ts_value_q <= '0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
            pass_q     <= pass_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        timeout_d  = timeout_q;
        pass_d     = pass_q;
        txn_go     = 1'b0;
        txn_addr   = ADDR_ID;

        case (state_q)
            ST_IDLE: begin
                if (start || AUTO_START) begin
                    state_d = ST_REQ_ID;
                    txn_go  = 1'b1;
                end
            end
            ST_REQ_ID, ST_WAIT_ID: begin
                if (txn_timed_out) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else if (txn_valid) begin
                    id_value_d = txn_data;
                    id_ok_d    = (txn_data == EXPECTED_ID);
                    state_d    = ST_REQ_TS;
                    txn_go     = 1'b1;
                    txn_addr   = ADDR_TS;
                end else if (state_q == ST_REQ_ID && !avm_waitrequest) begin
                    state_d = ST_WAIT_ID;
                end
            end
            ST_REQ_TS, ST_WAIT_TS: begin
                if (txn_timed_out) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else if (txn_valid) begin
                    ts_value_d = txn_data;
                    ts_ok_d    = (txn_data == EXPECTED_TS);
                    pass_d     = id_ok_q && (txn_data == EXPECTED_TS);
                    state_d    = ST_DONE;
                end else if (state_q == ST_REQ_TS && !avm_waitrequest) begin
                    state_d = ST_WAIT_TS;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d    = ST_REQ_ID;
                    txn_go     = 1'b1;
                    id_value_d = '0;
                    ts_value_d = '0;
                    id_ok_d    = 1'b0;
                    ts_ok_d    = 1'b0;
                    timeout_d  = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state_q == ST_REQ_ID) || (state_q == ST_WAIT_ID) ||
                      (state_q == ST_REQ_TS) || (state_q == ST_WAIT_TS);
    assign done     = (state_q == ST_DONE);
    assign pass     = pass_q;
    assign id_ok    = id_ok_q;
    assign ts_ok    = ts_ok_q;
    assign timeout  = timeout_q;
    assign id_value = id_value_q;
    assign ts_value = ts_value_q;

endmodule

// File: tb/tb_sysid_reader.sv
// Bench for sysid_reader: scripted reactive slave plus a transaction-level timing/result model.
module tb_sysid_reader;

    localparam int          T   = 16;
    localparam logic [31:0] EID = 32'h0000_1337;
    localparam logic [31:0] ETS = 32'h5672_A766;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b1;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    always #5 clock = ~clock;

    sysid_reader #(
        .EXPECTED_ID    (EID),
        .EXPECTED_TS    (ETS),
        .TIMEOUT_CYCLES (T),
        .AUTO_START     (1'b1)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .id_ok             (id_ok),
        .ts_ok             (ts_ok),
        .timeout           (timeout),
        .id_value          (id_value),
        .ts_value          (ts_value)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave script per read (index 0 = ID, 1 = TS): stall cycles, latency, data.
    int          s_sc[2];
    int          l_sc[2];
    logic [31:0] d_sc[2];
    int          pend, stall;
    logic [31:0] pdata;
    int          k_cyc = -1;
    bit          chk_en = 1'b0;
    int          busy_cnt = 0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // A read needing s stalls and latency l finishes only if data lands by count T-1.
    function automatic bit rd_tmo(input int s, input int l);
        return (s + l) > (T - 1);
    endfunction

    function automatic int rd_len(input int s, input int l);
        return rd_tmo(s, l) ? T : s + l + 1;
    endfunction

    function automatic int total_of(input int s0, input int l0, input int s1, input int l1);
        return rd_tmo(s0, l0) ? rd_len(s0, l0) : rd_len(s0, l0) + rd_len(s1, l1);
    endfunction

    task automatic compare_cycle(input int k);
        int          tot, n1;
        bit          t1, t2, in_busy, rd, ad, e_idok, e_tsok;
        logic [31:0] e_id, e_ts;
        tot = total_of(s_sc[0], l_sc[0], s_sc[1], l_sc[1]);
        n1  = rd_len(s_sc[0], l_sc[0]);
        t1  = rd_tmo(s_sc[0], l_sc[0]);
        t2  = !t1 && rd_tmo(s_sc[1], l_sc[1]);
        rd  = 1'b0;
        ad  = 1'b0;
        if (k <= imin(s_sc[0], T - 1)) begin
            rd = 1'b1;
        end else if (!t1 && k >= n1 && k <= n1 + imin(s_sc[1], T - 1)) begin
            rd = 1'b1;
            ad = 1'b1;
        end
        in_busy = (k < tot);
        if (busy === 1'b1) busy_cnt++;
        chk("busy", busy, in_busy);
        chk("done", done, !in_busy);
        chk("avm_read", avm_read, rd);
        if (rd) chk("avm_address", avm_address, ad);
        if (in_busy) begin
            chk("pass_busy", pass, 0);
            chk("timeout_busy", timeout, 0);
            if (k == 0) begin
                chk("id_value_cleared", id_value, 0);
                chk("ts_value_cleared", ts_value, 0);
            end
        end else begin
            e_id   = t1 ? 32'h0 : d_sc[0];
            e_ts   = (t1 || t2) ? 32'h0 : d_sc[1];
            e_idok = !t1 && (d_sc[0] == EID);
            e_tsok = !t1 && !t2 && (d_sc[1] == ETS);
            chk("id_value", id_value, e_id);
            chk("ts_value", ts_value, e_ts);
            chk("id_ok", id_ok, e_idok);
            chk("ts_ok", ts_ok, e_tsok);
            chk("timeout", timeout, t1 || t2);
            chk("pass", pass, e_idok && e_tsok && !(t1 || t2));
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (chk_en) begin
                k_cyc++;
                compare_cycle(k_cyc);
            end
        end
    end

    // Reactive slave, called once per cycle at the falling edge.
    task automatic slave_step();
        int idx;
        avm_readdatavalid = 1'b0;
        avm_readdata      = $urandom;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = pdata;
            end
        end
        if (avm_read === 1'b1) begin
            idx = (avm_address === 1'b1) ? 1 : 0;
            if (stall < s_sc[idx]) begin
                avm_waitrequest = 1'b1;
                stall++;
            end else begin
                avm_waitrequest = 1'b0;
                stall = 0;
                pend  = l_sc[idx];
                pdata = d_sc[idx];
            end
        end else begin
            avm_waitrequest = 1'b1;
            stall = 0;
        end
    endtask

    task automatic set_script(input int s0, input int l0, input logic [31:0] d0,
                              input int s1, input int l1, input logic [31:0] d1);
        s_sc[0] = s0; l_sc[0] = l0; d_sc[0] = d0;
        s_sc[1] = s1; l_sc[1] = l1; d_sc[1] = d1;
        pend  = 0;
        stall = 0;
    endtask

    // Called with the clock low; the next rising edge launches the check.
    task automatic run_check(input bit use_start, input bit inj,
                             input int s0, input int l0, input logic [31:0] d0,
                             input int s1, input int l1, input logic [31:0] d1,
                             input int sb_k, input int lit_busy, input int lit_pass);
        int tot;
        set_script(s0, l0, d0, s1, l1, d1);
        tot = total_of(s0, l0, s1, l1);
        avm_waitrequest   = 1'b1;
        avm_readdatavalid = inj;
        avm_readdata      = inj ? d1 : 32'h0;
        start    = use_start;
        k_cyc    = -1;
        busy_cnt = 0;
        chk_en   = 1'b1;
        for (int g = 0; g < tot + 4; g++) begin
            @(negedge clock);
            start = (k_cyc == sb_k);
            slave_step();
            if (k_cyc >= tot + 1) break;
        end
        chk_en = 1'b0;
        start  = 1'b0;
        chk("check_window", (k_cyc >= tot + 1), 1);
        if (lit_busy >= 0) chk("busy_cycles", busy_cnt, lit_busy);
        if (lit_pass >= 0) chk("pass_literal", pass, lit_pass);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_id_ok"}, id_ok, 0);
        chk({tag, "_ts_ok"}, ts_ok, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_id_value"}, id_value, 0);
        chk({tag, "_ts_value"}, ts_value, 0);
        chk({tag, "_avm_read"}, avm_read, 0);
        chk({tag, "_avm_address"}, avm_address, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total_cnt, bad_cnt);
        $fatal(1);
    end

    initial begin
        int s0, l0, s1, l1, sbk, tot;
        logic [31:0] d0, d1;

        // Reset held 5 cycles, then auto-start; start pulse while busy is ignored.
        repeat (5) @(negedge clock);
        chk_all_zero("reset");
        reset = 1'b0;
        run_check(1'b0, 1'b0, 0, 1, EID, 0, 1, ETS, 1, 4, 1);

        // Zero-wait, latency-1 check from a start pulse.
        run_check(1'b1, 1'b0, 0, 1, EID, 0, 1, ETS, -1, 4, 1);
        // Three stall cycles on each read.
        run_check(1'b1, 1'b0, 3, 1, EID, 3, 1, ETS, 2, 10, 1);
        // Timestamp off by one.
        run_check(1'b1, 1'b0, 0, 1, EID, 0, 1, 32'h5672_A767, -1, 4, 0);
        chk("ts_value_literal", ts_value, 32'h5672_A767);
        chk("ts_ok_literal", ts_ok, 0);
        chk("id_ok_literal", id_ok, 1);
        // ID read never returns data.
        run_check(1'b1, 1'b0, 0, 1000, EID, 0, 1, ETS, -1, 16, 0);
        chk("timeout_literal", timeout, 1);
        chk("id_value_literal", id_value, 0);
        chk("avm_read_after_abort", avm_read, 0);
        // Start coincident with the final data beat.
        run_check(1'b1, 1'b0, 0, 1, EID, 0, 1, ETS, 3, 4, 1);

        // Reset while waiting for timestamp data, then a late readdatavalid.
        set_script(0, 1, EID, 0, 50, ETS);
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            start = 1'b0;
            slave_step();
        end
        chk("mid_busy", busy, 1);
        chk("mid_avm_read", avm_read, 0);
        chk("mid_id_value", id_value, EID);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk_all_zero("midreset");
        run_check(1'b0, 1'b1, 0, 1, EID, 0, 1, ETS, -1, 4, 1);
        run_check(1'b1, 1'b0, 0, 1, EID, 0, 1, ETS, -1, 4, 1);

        // Randomized checks.
        for (int n = 0; n < 40; n++) begin
            s0 = $urandom_range(0, 7);
            l0 = $urandom_range(1, 9);
            s1 = $urandom_range(0, 7);
            l1 = $urandom_range(1, 9);
            d0 = ($urandom_range(0, 3) == 0) ? (EID ^ (32'h1 << $urandom_range(0, 31))) : EID;
            d1 = ($urandom_range(0, 3) == 0) ? (ETS ^ (32'h1 << $urandom_range(0, 31))) : ETS;
            tot = total_of(s0, l0, s1, l1);
            sbk = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, tot - 1);
            run_check(1'b1, 1'b0, s0, l0, d0, s1, l1, d1, sbk, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
